seq_divider: RTL

Parametrised multi-cycle unsigned/signed integer divider for the arithmetic unit, successor to the single-cycle 8-bit combinational divider. Computes one quotient bit per clock with a restoring shift-subtract datapath, trading latency for area and timing at larger widths. Sits beside the adder/multiplier in the ALU datapath behind a start/done handshake and flags divide-by-zero explicitly.

---
 rtl/seq_divider_if.sv | 45 ++++
 rtl/seq_divider.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if
// Handshake and operand/result bundle for seq_divider.
//   start       : request, sampled by the divider only while busy=0
//   a, b        : dividend / divisor (WIDTH bits)
//   is_signed   : two's-complement mode (only when DIVIDER_SIGNED_EN is defined)
//   busy        : operation in progress
//   done        : one-cycle pulse, results valid
//   quotient    : a / b
//   remainder   : a % b
//   div_by_zero : last operation had b = 0
// Modports: master (requester side), slave (divider side).
// Optional feature macro: DIVIDER_SIGNED_EN.
// -----------------------------------------------------------------------------
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef DIVIDER_SIGNED_EN
    logic             is_signed;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, a, b,
`ifdef DIVIDER_SIGNED_EN
        output is_signed,
`endif
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, a, b,
`ifdef DIVIDER_SIGNED_EN
        input  is_signed,
`endif
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle restoring shift-subtract integer divider, one quotient bit per
// clock, behind a start/busy/done handshake with explicit divide-by-zero flag.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : seq_divider_if.slave (start, a, b, [is_signed], busy, done,
//            quotient, remainder, div_by_zero)
// Latency from the accepting edge k: done after edge k+WIDTH+1 (unsigned),
// k+WIDTH+2 (signed op, extra FIX cycle), k+1 when b = 0.
// Optional feature macro: DIVIDER_SIGNED_EN (is_signed input and FIX state).
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);
    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
`ifdef DIVIDER_SIGNED_EN
        ,
        S_FIX  = 2'd3
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;      // partial remainder, one spare bit
    logic [WIDTH-1:0] dvd_q, dvd_d;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_q, dvs_d;      // divisor magnitude
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;
`ifdef DIVIDER_SIGNED_EN
    logic             op_signed_q, op_signed_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
`endif

    // Operand magnitudes at accept; an unsigned op never negates.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

`ifdef DIVIDER_SIGNED_EN
    assign a_neg = bus.is_signed & bus.a[WIDTH-1];
    assign b_neg = bus.is_signed & bus.b[WIDTH-1];
`else
    assign a_neg = 1'b0;
    assign b_neg = 1'b0;
`endif
    // MIN negates to itself, which is still the correct unsigned magnitude.
    assign a_mag = a_neg ? -bus.a : bus.a;
    assign b_mag = b_neg ? -bus.b : bus.b;

    // One restoring step: shift the next dividend bit into the remainder and
    // compare against the divisor.
    logic [WIDTH+1:0] shift_w;
    logic             fits;

    assign shift_w = {rem_q, dvd_q[WIDTH-1]};
    assign fits    = (shift_w >= {2'b00, dvs_q});

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
`ifdef DIVIDER_SIGNED_EN
        op_signed_d = op_signed_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    dvd_d = a_mag;
                    dvs_d = b_mag;
                    rem_d = '0;
                    cnt_d = '0;
`ifdef DIVIDER_SIGNED_EN
                    op_signed_d = bus.is_signed;
                    q_neg_d     = a_neg ^ b_neg;
                    r_neg_d     = a_neg;
`endif
                    if (bus.b == '0) begin
                        // Skip CALC; zero the datapath so DONE publishes 0/0.
                        dvd_d   = '0;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        dbz_d   = 1'b0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d = fits ? (WIDTH+1)'(shift_w - {2'b00, dvs_q})
                             : shift_w[WIDTH:0];
                dvd_d = {dvd_q[WIDTH-2:0], fits};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
`ifdef DIVIDER_SIGNED_EN
                    state_d = op_signed_q ? S_FIX : S_DONE;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef DIVIDER_SIGNED_EN
            S_FIX: begin
                // Truncation toward zero: quotient negative when signs
                // differ, remainder follows the dividend's sign.
                if (q_neg_q) dvd_d = -dvd_q;
                if (r_neg_q) rem_d = {1'b0, -rem_q[WIDTH-1:0]};
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                quot_d  = dvd_q;
                remo_d  = rem_q[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            op_signed_q <= 1'b0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
`ifdef DIVIDER_SIGNED_EN
            op_signed_q <= op_signed_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
`endif
        end
    end

`ifdef DIVIDER_SIGNED_EN
    assign bus.busy = (state_q == S_CALC) || (state_q == S_FIX);
`else
    assign bus.busy = (state_q == S_CALC);
`endif
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = remo_q;
    assign bus.div_by_zero = dbz_q;

endmodule
